// File: rtl/dp_geno_rr_dispatcher.sv
// Registered round-robin dispatcher: holds one genotyping job and hands it to exactly one
// ready PairHMM DP engine, rotating priority after every dispatch.
module dp_geno_rr_dispatcher #(
    parameter int unsigned NUM_DP          = 4,
    parameter int unsigned HAP_MAX_LENGTH  = 512,
    parameter int unsigned READ_MAX_LENGTH = 512,
    parameter int unsigned GENO_SRAM_WORDS = 1024,
    localparam int unsigned AW  = $clog2(GENO_SRAM_WORDS),
    localparam int unsigned HLW = $clog2(HAP_MAX_LENGTH) + 1,
    localparam int unsigned RLW = $clog2(READ_MAX_LENGTH) + 1,
    localparam int unsigned GW  = $clog2(NUM_DP),
    localparam int unsigned PW  = 2 * HAP_MAX_LENGTH + 4 * READ_MAX_LENGTH + HLW + RLW + AW
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_geno_valid,
    output logic                           o_geno_ready,
    input  logic [2*HAP_MAX_LENGTH-1:0]    i_geno_sequence_A,
    input  logic [2*READ_MAX_LENGTH-1:0]   i_geno_sequence_B,
    input  logic [2*READ_MAX_LENGTH-1:0]   i_geno_sequence_B_qualities,
    input  logic [HLW-1:0]                 i_geno_seq_A_length,
    input  logic [RLW-1:0]                 i_geno_seq_B_length,
    input  logic [AW-1:0]                  i_geno_address_ID,
    input  logic [NUM_DP-1:0]              i_dp_ready,
    output logic [NUM_DP-1:0]              o_dp_valid,
    output logic [PW-1:0]                  o_dp_payload,
    output logic [GW-1:0]                  o_last_grant,
    output logic [31:0]                    o_jobs_dispatched
);

    typedef enum logic {StEmpty, StHold} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     payload_q, payload_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [31:0]       jobs_q, jobs_d;

    logic [GW-1:0]     grant;
    logic              any_rdy;
    logic              found;
    logic              accept;
    logic              dispatch;

    // Rotating search: first ready engine at or above rr_ptr, wrapping to 0.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        any_rdy = |i_dp_ready;
        for (int unsigned i = 0; i < NUM_DP; i++) begin
            logic [GW-1:0] idx;
            idx = GW'((32'(rr_ptr_q) + i) % NUM_DP);
            if (!found && i_dp_ready[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign dispatch = (state_q == StHold) && any_rdy;
    assign accept   = i_geno_valid && o_geno_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StHold;
        end else if (dispatch) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        o_geno_ready = (state_q == StEmpty) || any_rdy;
        o_dp_valid   = '0;
        if (dispatch) begin
            o_dp_valid = NUM_DP'(1) << grant;
        end
    end

    always_comb begin
        payload_d    = payload_q;
        rr_ptr_d     = rr_ptr_q;
        last_grant_d = last_grant_q;
        jobs_d       = jobs_q;
        if (accept) begin
            payload_d = {i_geno_sequence_A, i_geno_sequence_B, i_geno_sequence_B_qualities,
                         i_geno_seq_A_length, i_geno_seq_B_length, i_geno_address_ID};
        end
        if (dispatch) begin
            rr_ptr_d     = (grant == GW'(NUM_DP - 1)) ? '0 : grant + GW'(1);
            last_grant_d = grant;
            jobs_d       = jobs_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q    <= '0;
            rr_ptr_q     <= '0;
            last_grant_q <= '0;
            jobs_q       <= '0;
        end else begin
            payload_q    <= payload_d;
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            jobs_q       <= jobs_d;
        end
    end

    assign o_dp_payload      = payload_q;
    assign o_last_grant      = last_grant_q;
    assign o_jobs_dispatched = jobs_q;

endmodule

// File: tb/tb_dp_geno_rr_dispatcher.sv
// Bench for dp_geno_rr_dispatcher: directed scenarios plus random ready/valid traffic, with a
// scoreboard of accepted jobs and a round-robin reference model checked every cycle.
module tb_dp_geno_rr_dispatcher;

    localparam int unsigned NUM_DP = 4;
    localparam int unsigned HAP    = 512;
    localparam int unsigned READ   = 512;
    localparam int unsigned WORDS  = 1024;
    localparam int unsigned AW     = $clog2(WORDS);
    localparam int unsigned HLW    = $clog2(HAP) + 1;
    localparam int unsigned RLW    = $clog2(READ) + 1;
    localparam int unsigned GW     = $clog2(NUM_DP);
    localparam int unsigned PW     = 2 * HAP + 4 * READ + HLW + RLW + AW;

    logic                  clk;
    logic                  rst_n;
    logic                  i_geno_valid;
    logic                  o_geno_ready;
    logic [2*HAP-1:0]      seq_a;
    logic [2*READ-1:0]     seq_b;
    logic [2*READ-1:0]     seq_q;
    logic [HLW-1:0]        len_a;
    logic [RLW-1:0]        len_b;
    logic [AW-1:0]         addr_id;
    logic [NUM_DP-1:0]     i_dp_ready;
    logic [NUM_DP-1:0]     o_dp_valid;
    logic [PW-1:0]         o_dp_payload;
    logic [GW-1:0]         o_last_grant;
    logic [31:0]           o_jobs_dispatched;

    int n_checks = 0;
    int n_fail   = 0;

    dp_geno_rr_dispatcher #(
        .NUM_DP          (NUM_DP),
        .HAP_MAX_LENGTH  (HAP),
        .READ_MAX_LENGTH (READ),
        .GENO_SRAM_WORDS (WORDS)
    ) u_dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .i_geno_valid                (i_geno_valid),
        .o_geno_ready                (o_geno_ready),
        .i_geno_sequence_A           (seq_a),
        .i_geno_sequence_B           (seq_b),
        .i_geno_sequence_B_qualities (seq_q),
        .i_geno_seq_A_length         (len_a),
        .i_geno_seq_B_length         (len_b),
        .i_geno_address_ID           (addr_id),
        .i_dp_ready                  (i_dp_ready),
        .o_dp_valid                  (o_dp_valid),
        .o_dp_payload                (o_dp_payload),
        .o_last_grant                (o_last_grant),
        .o_jobs_dispatched           (o_jobs_dispatched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int rr, input logic [NUM_DP-1:0] rdy);
        for (int i = 0; i < NUM_DP; i++) begin
            int k;
            k = (rr + i) % NUM_DP;
            if (rdy[k]) return k;
        end
        return 0;
    endfunction

    // Reference model state, owned entirely by the monitor process.
    logic [PW-1:0] sb_q[$];
    bit            m_full;
    int            m_rr;
    int            m_last;
    logic [31:0]   m_cnt;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            m_full = 1'b0;
            m_rr   = 0;
            m_last = 0;
            m_cnt  = '0;
        end else begin
            logic          any;
            int            g;
            logic [PW-1:0] exp_p;
            bit            exp_rdy;
            bit            disp;
            logic [NUM_DP-1:0] exp_v;
            any     = |i_dp_ready;
            g       = rr_pick(m_rr, i_dp_ready);
            disp    = m_full && any;
            exp_rdy = !m_full || any;
            exp_v   = disp ? (NUM_DP'(1) << g) : '0;
            check_eq("last_grant", 64'(o_last_grant), 64'(m_last));
            check_eq("jobs_dispatched", 64'(o_jobs_dispatched), 64'(m_cnt));
            check_eq("valid_onehot0", 64'($onehot0(o_dp_valid)), 64'(1));
            check_eq("dp_valid", 64'(o_dp_valid), 64'(exp_v));
            check_eq("geno_ready", 64'(o_geno_ready), 64'(exp_rdy));
            if (disp) begin
                if (sb_q.size() == 0) begin
                    check_eq("scoreboard_nonempty", 64'(0), 64'(1));
                end else begin
                    exp_p = sb_q.pop_front();
                    check_eq("payload_id", 64'(o_dp_payload[AW-1:0]), 64'(exp_p[AW-1:0]));
                    check_eq("payload_match", 64'(o_dp_payload === exp_p), 64'(1));
                end
                m_rr   = (g + 1) % NUM_DP;
                m_last = g;
                m_cnt  = m_cnt + 32'd1;
            end
            if (i_geno_valid && exp_rdy) begin
                sb_q.push_back({seq_a, seq_b, seq_q, len_a, len_b, addr_id});
                m_full = 1'b1;
            end else if (disp) begin
                m_full = 1'b0;
            end
        end
    end

    int unsigned   next_id = 0;
    logic [PW-1:0] drv_payload;

    // Present a fresh random job (or idle) and an engine-ready pattern for one cycle.
    task automatic drive(input bit v, input logic [NUM_DP-1:0] rdy);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2 * HAP / 32; k++) seq_a[k*32 +: 32] = $urandom;
        for (int k = 0; k < 2 * READ / 32; k++) begin
            seq_b[k*32 +: 32] = $urandom;
            seq_q[k*32 +: 32] = $urandom;
        end
        len_a        = HLW'($urandom_range(1, HAP));
        len_b        = RLW'($urandom_range(1, READ));
        addr_id      = AW'(next_id);
        next_id      = next_id + 1;
        i_geno_valid = v;
        i_dp_ready   = rdy;
        drv_payload  = {seq_a, seq_b, seq_q, len_a, len_b, addr_id};
    endtask

    initial begin
        logic [PW-1:0] held;
        rst_n        = 1'b0;
        i_geno_valid = 1'b0;
        i_dp_ready   = '0;
        seq_a = '0; seq_b = '0; seq_q = '0; len_a = '0; len_b = '0; addr_id = '0;
        #23;
        check_eq("rst_dp_valid", 64'(o_dp_valid), 64'(0));
        check_eq("rst_geno_ready", 64'(o_geno_ready), 64'(1));
        check_eq("rst_payload_zero", 64'(o_dp_payload == '0), 64'(1));
        check_eq("rst_jobs", 64'(o_jobs_dispatched), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back jobs with every engine ready.
        for (int i = 0; i < 8; i++) drive(1'b1, 4'hF);
        drive(1'b0, 4'hF);
        drive(1'b0, 4'hF);
        @(negedge clk);
        check_eq("t1_jobs", 64'(o_jobs_dispatched), 64'(8));
        check_eq("t1_last_grant", 64'(o_last_grant), 64'(3));

        // No engine ready: job stalls, then a single engine drains it.
        drive(1'b1, 4'h0);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h0);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'h0);
        @(negedge clk);
        check_eq("t2_last_grant", 64'(o_last_grant), 64'(2));

        // rr_ptr is 3; ready only on 0 and 1 forces a wrap.
        drive(1'b1, 4'b0011);
        drive(1'b0, 4'b0011);
        drive(1'b1, 4'b0011);
        drive(1'b0, 4'b0011);
        drive(1'b0, 4'h0);
        @(negedge clk);
        check_eq("t3_last_grant", 64'(o_last_grant), 64'(1));

        // Accept a new job in the cycle the held job dispatches.
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        held = drv_payload;
        drive(1'b1, 4'h0);
        @(negedge clk);
        check_eq("t4_held_payload", 64'(o_dp_payload === held), 64'(1));
        check_eq("t4_full_not_ready", 64'(o_geno_ready), 64'(0));

        // Asynchronous reset while a job is held.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t5_valid", 64'(o_dp_valid), 64'(0));
        check_eq("t5_jobs", 64'(o_jobs_dispatched), 64'(0));
        check_eq("t5_last_grant", 64'(o_last_grant), 64'(0));
        i_geno_valid = 1'b0;
        i_dp_ready   = 4'hF;
        #1;
        check_eq("t5_no_dispatch", 64'(o_dp_valid), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 4'b1001);
        drive(1'b0, 4'b1001);
        drive(1'b0, 4'h0);
        @(negedge clk);
        check_eq("t5_rr_restart", 64'(o_last_grant), 64'(0));
        check_eq("t5_jobs_after", 64'(o_jobs_dispatched), 64'(1));

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), NUM_DP'($urandom_range(0, 15)));
        end
        drive(1'b0, 4'hF);
        drive(1'b0, 4'hF);
        @(negedge clk);
        check_eq("t6_scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
